// File: rtl/opc5_mem_arbiter.sv
// opc5_mem_arbiter: two-requester arbiter/sequencer for the single-port OPC5 system memory.
// Optional feature macro: OPC5_ARB_ROUND_ROBIN_EN (round-robin tie-break instead of fixed priority).
module opc5_mem_arbiter #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 1
) (
    input  logic          clk_i,
    input  logic          reset_b_i,
    input  logic          req0_valid_i,
    input  logic          req0_rnw_i,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_wdata_i,
    output logic          req0_ack_o,
    output logic [DW-1:0] req0_rdata_o,
    input  logic          req1_valid_i,
    input  logic          req1_rnw_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_wdata_i,
    output logic          req1_ack_o,
    output logic [DW-1:0] req1_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          mem_ceb_o,
    output logic          mem_oeb_o,
    output logic          mem_web_o,
    output logic          busy_o
);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ceb_q, ceb_d;
    logic          oeb_q, oeb_d;
    logic          web_q, web_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          tie_win;
    logic          win;

`ifdef OPC5_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // last-grant pointer: a tie goes to whoever was not served last
    always_ff @(posedge clk_i) begin
        if (!reset_b_i) last_q <= 1'b1;
        else            last_q <= last_d;
    end

    assign tie_win = ~last_q;
    assign last_d  = (state_q == IDLE && (req0_valid_i || req1_valid_i)) ? win : last_q;
`else
    assign tie_win = 1'b0;
`endif

    // requester 1 wins when it is alone or when the tie-break favours it
    assign win = req1_valid_i & (~req0_valid_i | tie_win);

    // state, latched request fields, registered strobes and per-requester read data
    always_ff @(posedge clk_i) begin
        if (!reset_b_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            rnw_q    <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            ceb_q    <= 1'b1;
            oeb_q    <= 1'b1;
            web_q    <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ceb_q    <= ceb_d;
            oeb_q    <= oeb_d;
            web_q    <= web_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // next-state logic; strobes are derived from the next state so they leave the flops clean
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    sel_d   = win;
                    rnw_d   = win ? req1_rnw_i : req0_rnw_i;
                    addr_d  = win ? req1_addr_i : req0_addr_i;
                    wdata_d = win ? req1_wdata_i : req0_wdata_i;
                    cnt_d   = CW'(WAIT);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = ACK;
                    rdata0_d = (rnw_q && !sel_q) ? mem_rdata_i : rdata0_q;
                    rdata1_d = (rnw_q && sel_q) ? mem_rdata_i : rdata1_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ceb_d = state_d != ACCESS;
        oeb_d = !(state_d == ACCESS && rnw_d);
        web_d = !(state_d == ACCESS && !rnw_d);
    end

    assign req0_ack_o   = state_q == ACK && !sel_q;
    assign req1_ack_o   = state_q == ACK && sel_q;
    assign req0_rdata_o = rdata0_q;
    assign req1_rdata_o = rdata1_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_ceb_o    = ceb_q;
    assign mem_oeb_o    = oeb_q;
    assign mem_web_o    = web_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// tb_opc5_mem_arbiter: scoreboard bench for opc5_mem_arbiter (main WAIT=1, plus WAIT=0/15 latency instances).
module tb_opc5_mem_arbiter;
    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    logic        r0v, r0rnw, r1v, r1rnw;
    logic [15:0] r0a, r0wd, r1a, r1wd;
    logic        ack0, ack1, ceb, oeb, web, busy;
    logic [15:0] rd0, rd1, maddr, mwd, mrd;

    opc5_mem_arbiter #(.AW(16), .DW(16), .WAIT(1)) dut (
        .clk_i(clk), .reset_b_i(reset_b),
        .req0_valid_i(r0v), .req0_rnw_i(r0rnw), .req0_addr_i(r0a), .req0_wdata_i(r0wd),
        .req0_ack_o(ack0), .req0_rdata_o(rd0),
        .req1_valid_i(r1v), .req1_rnw_i(r1rnw), .req1_addr_i(r1a), .req1_wdata_i(r1wd),
        .req1_ack_o(ack1), .req1_rdata_o(rd1),
        .mem_addr_o(maddr), .mem_wdata_o(mwd), .mem_rdata_i(mrd),
        .mem_ceb_o(ceb), .mem_oeb_o(oeb), .mem_web_o(web), .busy_o(busy)
    );

    logic        lv0, lv15;
    logic        la0, la15, lb0, lb15, lc0, lc15, lo0, lo15, lw0, lw15, lbz0, lbz15;
    logic [15:0] lr0, lr15, lq0, lq15, lma0, lma15, lmw0, lmw15;

    opc5_mem_arbiter #(.AW(16), .DW(16), .WAIT(0)) u_w0 (
        .clk_i(clk), .reset_b_i(reset_b),
        .req0_valid_i(lv0), .req0_rnw_i(1'b1), .req0_addr_i(16'h0005), .req0_wdata_i(16'h0),
        .req0_ack_o(la0), .req0_rdata_o(lr0),
        .req1_valid_i(1'b0), .req1_rnw_i(1'b1), .req1_addr_i(16'h0), .req1_wdata_i(16'h0),
        .req1_ack_o(lb0), .req1_rdata_o(lq0),
        .mem_addr_o(lma0), .mem_wdata_o(lmw0), .mem_rdata_i(16'h5A5A),
        .mem_ceb_o(lc0), .mem_oeb_o(lo0), .mem_web_o(lw0), .busy_o(lbz0)
    );

    opc5_mem_arbiter #(.AW(16), .DW(16), .WAIT(15)) u_w15 (
        .clk_i(clk), .reset_b_i(reset_b),
        .req0_valid_i(lv15), .req0_rnw_i(1'b1), .req0_addr_i(16'h0005), .req0_wdata_i(16'h0),
        .req0_ack_o(la15), .req0_rdata_o(lr15),
        .req1_valid_i(1'b0), .req1_rnw_i(1'b1), .req1_addr_i(16'h0), .req1_wdata_i(16'h0),
        .req1_ack_o(lb15), .req1_rdata_o(lq15),
        .mem_addr_o(lma15), .mem_wdata_o(lmw15), .mem_rdata_i(16'h5A5A),
        .mem_ceb_o(lc15), .mem_oeb_o(lo15), .mem_web_o(lw15), .busy_o(lbz15)
    );

    // memory model: preset contents plus whatever the DUT writes
    logic [15:0] wmem [65536];
    bit          wdone [65536];

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0123: return 16'hBEEF;
            16'h0010: return 16'h0F0F;
            16'h0020: return 16'h0202;
            16'h0200: return 16'h1111;
            16'h0300: return 16'h2222;
            default:  return 16'h0000;
        endcase
    endfunction

    assign mrd = wdone[maddr] ? wmem[maddr] : rom(maddr);

    always @(posedge clk) begin
        if (!ceb && !web) begin
            wmem[maddr]  <= mwd;
            wdone[maddr] <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    typedef struct packed {
        logic        id;
        logic        rnw;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!ceb) chk("web_oeb_excl", {31'b0, web | oeb}, 32'd1);
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                chk("unexp_ack", {31'b0, ack0 | ack1}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_both", {31'b0, ack0 & ack1}, 32'd0);
                chk("ack_id", {31'b0, ack1}, {31'b0, e.id});
                if (e.rnw) chk("rdata", {16'b0, e.id ? rd1 : rd0}, {16'b0, e.data});
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic xfer(input bit id, input bit rnw, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_d, output int lat, output int nce, output int noe,
                        output int nwe);
        @(negedge clk);
        sb.push_back(exp_t'{id, rnw, exp_d});
        if (id) begin
            r1rnw = rnw; r1a = a; r1wd = wd; r1v = 1'b1;
        end else begin
            r0rnw = rnw; r0a = a; r0wd = wd; r0v = 1'b1;
        end
        lat = 0; nce = 0; noe = 0; nwe = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lat++;
            if (!ceb) nce++;
            if (!oeb) noe++;
            if (!web) nwe++;
            if (id ? ack1 : ack0) break;
        end
        chk("xfer_ack_seen", {31'b0, id ? ack1 : ack0}, 32'd1);
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    int lat, nce, noe, nwe, a0, a1, q0, q1, l0, l15;

    initial begin
        reset_b = 1'b0;
        r0v = 0; r0rnw = 1; r0a = 0; r0wd = 0;
        r1v = 0; r1rnw = 1; r1a = 0; r1wd = 0;
        lv0 = 0; lv15 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ceb", {31'b0, ceb}, 32'd1);
        chk("rst_oeb", {31'b0, oeb}, 32'd1);
        chk("rst_web", {31'b0, web}, 32'd1);
        chk("rst_addr", {16'b0, maddr}, 32'd0);
        chk("rst_wdata", {16'b0, mwd}, 32'd0);
        chk("rst_acks", {30'b0, ack1, ack0}, 32'd0);
        chk("rst_rdata", {rd1, rd0}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset_b = 1'b1;

        xfer(1'b0, 1'b1, 16'h0123, 16'h0, 16'hBEEF, lat, nce, noe, nwe);
        chk("rd_latency", lat, 32'd3);
        chk("rd_ceb_cycles", nce, 32'd2);
        chk("rd_oeb_cycles", noe, 32'd2);
        chk("rd_web_cycles", nwe, 32'd0);
        chk("rd_rdata0", {16'b0, rd0}, 32'h0000BEEF);
        chk("rd_rdata1_hold", {16'b0, rd1}, 32'd0);

        xfer(1'b1, 1'b0, 16'h8000, 16'hA5A5, 16'h0, lat, nce, noe, nwe);
        chk("wr_latency", lat, 32'd3);
        chk("wr_web_cycles", nwe, 32'd2);
        chk("wr_oeb_cycles", noe, 32'd0);
        chk("wr_ceb_cycles", nce, 32'd2);
        xfer(1'b0, 1'b1, 16'h8000, 16'h0, 16'hA5A5, lat, nce, noe, nwe);
        chk("wr_readback", {16'b0, rd0}, 32'h0000A5A5);
        chk("wr_rdata1_hold", {16'b0, rd1}, 32'd0);

        @(negedge clk);
        sb.push_back(exp_t'{1'b0, 1'b1, 16'h0F0F});
        r0rnw = 1'b1; r0a = 16'h0010; r0v = 1'b1;
        @(negedge clk);
        chk("fc_addr_first", {16'b0, maddr}, 32'h00000010);
        r0a = 16'h0020;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("fc_addr_hold", {16'b0, maddr}, 32'h00000010);
            if (ack0) break;
        end
        chk("fc_ack_seen", {31'b0, ack0}, 32'd1);
        r0v = 1'b0;

        @(negedge clk);
        r0rnw = 1'b0; r0a = 16'h0040; r0wd = 16'h1234; r0v = 1'b1;
        @(negedge clk);
        chk("mr_in_access", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("mr_web_low", {31'b0, web}, 32'd0);
        reset_b = 1'b0;
        r0v = 1'b0;
        @(negedge clk);
        chk("mr_ceb", {31'b0, ceb}, 32'd1);
        chk("mr_web", {31'b0, web}, 32'd1);
        chk("mr_oeb", {31'b0, oeb}, 32'd1);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_no_ack", {31'b0, ack0}, 32'd0);
        end
        xfer(1'b0, 1'b1, 16'h0123, 16'h0, 16'hBEEF, lat, nce, noe, nwe);
        chk("mr_after_latency", lat, 32'd3);

        pulse_reset();
`ifdef OPC5_ARB_ROUND_ROBIN_EN
        q0 = 2; q1 = 2;
        sb.push_back(exp_t'{1'b0, 1'b1, 16'h1111});
        sb.push_back(exp_t'{1'b1, 1'b1, 16'h2222});
        sb.push_back(exp_t'{1'b0, 1'b1, 16'h1111});
        sb.push_back(exp_t'{1'b1, 1'b1, 16'h2222});
`else
        q0 = 4; q1 = 1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_t'{1'b0, 1'b1, 16'h1111});
        sb.push_back(exp_t'{1'b1, 1'b1, 16'h2222});
`endif
        @(negedge clk);
        r0rnw = 1'b1; r0a = 16'h0200; r1rnw = 1'b1; r1a = 16'h0300;
        r0v = 1'b1; r1v = 1'b1;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack0) begin
                a0++;
                if (a0 == q0) r0v = 1'b0;
            end
            if (ack1) begin
                a1++;
                if (a1 == q1) r1v = 1'b0;
            end
            if (a0 + a1 == q0 + q1) break;
        end
        chk("tie_acks0", a0, q0);
        chk("tie_acks1", a1, q1);
        r0v = 1'b0; r1v = 1'b0;

        @(negedge clk);
        lv0 = 1'b1; lv15 = 1'b1;
        l0 = 0; l15 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (la0 && l0 == 0) begin
                l0 = n;
                lv0 = 1'b0;
            end
            if (la15 && l15 == 0) begin
                l15 = n;
                lv15 = 1'b0;
            end
            if (l0 != 0 && l15 != 0) break;
        end
        chk("lat_wait0", l0, 32'd2);
        chk("lat_wait15", l15, 32'd17);
        chk("lat_rdata0", {16'b0, lr0}, 32'h00005A5A);
        chk("lat_rdata15", {16'b0, lr15}, 32'h00005A5A);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/opc5_mem_arbiter.md
# opc5_mem_arbiter

Two-requester arbiter and sequencer for the single-port 64K x 16 OPC5 system memory. It sits between the CPU bus master (requester 0) and a secondary master such as a DMA or loader (requester 1), and drives the memory's chip-enable, output-enable and write-enable strobes. Each access is sequenced through a fixed number of wait states, and a one-cycle acknowledge is returned to the winning requester. Read data is registered per requester.

## Interface
- AW, 16, address width
- DW, 16, data width
- WAIT, 1, extra access cycles per transfer beyond the first (0..15)

- clk  in  1  system clock; all state changes on rising edge
- reset_b  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 (CPU) access request; held until req0_ack
- req0_rnw  in  1  1 = read, 0 = write
- req0_addr  in  AW  word address
- req0_wdata  in  DW  write data
- req0_ack  out  1  one-cycle completion pulse
- req0_rdata  out  DW  registered read data, valid from the ack cycle onward
- req1_valid / req1_rnw / req1_addr / req1_wdata / req1_ack / req1_rdata  same as requester 0, for requester 1
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data; the top level provides the tristate
- mem_rdata  in  DW  memory read data
- mem_ceb  out  1  chip enable, active-low
- mem_oeb  out  1  output enable, active-low
- mem_web  out  1  write enable, active-low
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states:
  - IDLE: mem_ceb, mem_oeb and mem_web are all high. If any valid is high, the winner is chosen and its rnw, addr and wdata are latched into internal registers. An access counter is loaded with WAIT. Next state is ACCESS.
  - ACCESS: mem_ceb is low.
    - Read: mem_oeb is low and mem_web is high.
    - Write: mem_web is low and mem_oeb is high.
    - The counter decrements each cycle. When the counter is 0, a read captures mem_rdata into the winner's rdata register, and the next state is ACK.
  - ACK: all strobes are high. The winner's ack is high for exactly this cycle. Next state is IDLE.
- Only the winner's rdata register is updated. The other requester's rdata holds its value.
- Requester protocol:
  - valid and the fields are held stable until ack is sampled.
  - valid drops in the cycle after ack, or stays high to issue the next request.
  - Fields are latched in IDLE, so changes made while the request is in ACCESS are ignored.
- Arbitration is evaluated only in IDLE. Once a transfer is granted it is never pre-empted.
- The default priority is fixed: requester 0 wins on a tie.
- mem_addr and mem_wdata are driven from the latched registers and hold their last value while in IDLE.
- A valid that drops before ack is a protocol violation. The transfer still completes and the ack is still issued.

## Timing
- Reset values: state IDLE; mem_ceb = mem_oeb = mem_web = 1; mem_addr = 0; mem_wdata = 0; ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0; round-robin pointer = 1.
- Latency from the edge that samples valid in IDLE to ack high: WAIT + 2 cycles.
- ACCESS lasts WAIT + 1 cycles.
- Back-to-back throughput is one transfer per WAIT + 3 cycles.
- mem_rdata is sampled at the rising edge that ends the last ACCESS cycle.
- Strobes are registered outputs and never glitch. mem_web is never low in the same cycle as mem_oeb.
- If reset_b is low at any edge, including mid-ACCESS:
  - state goes to IDLE;
  - strobes go high next cycle;
  - no ack is issued;
  - the pending transfer is dropped.

## Configuration
- OPC5_ARB_ROUND_ROBIN_EN:
  - Defined: on a tie, the requester not granted last wins. A 1-bit last-grant pointer is updated on every grant; its reset value is 1, so requester 0 wins the first tie.
  - Undefined: fixed priority, requester 0 always wins a tie. The pointer logic is absent.

## Test plan
- Single read, WAIT=1, mem[0x0123]=0xBEEF, req0 read 0x0123:
  - required: mem_ceb low for 2 cycles with mem_oeb low;
  - required: req0_ack is 3 cycles after grant and req0_rdata=0xBEEF;
  - required: req1_rdata stays 0.
- Single write, req1 write 0xA5A5 to 0x8000:
  - required: mem_web low for WAIT+1 cycles and mem_oeb high throughout;
  - required: req1_ack once, and a subsequent read of 0x8000 returns 0xA5A5.
- Simultaneous valid on both requesters, held high for 4 transfers:
  - fixed priority: grant order 0,0,0,0, with req1 starved while req0 stays valid;
  - with OPC5_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
- WAIT=0 and WAIT=15: measured valid-to-ack latency is 2 and 17 cycles respectively.
- Reset mid-ACCESS: reset_b low in the 2nd ACCESS cycle of a write:
  - required: strobes high on the next cycle, no ack, busy=0;
  - required: a new request after reset completes normally.
- Field change during ACCESS: req0_addr changed from 0x0010 to 0x0020 mid-transfer:
  - required: mem_addr stays 0x0010 until ack.
